// File: rtl/cpu_types_pkg.sv
// Types shared by the cores, the memory controller and the RAM model.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

endpackage

// File: rtl/ram_arb_pkg.sv
// State and operation encodings for the RAM port arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RETRY
    } arb_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

endpackage

// File: rtl/ram_port_arbiter_rr_picker.sv
// Combinational winner select: lowest aged index, else round robin from rr_ptr.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] active,
    input  logic [IW-1:0]   rr_ptr,
    input  logic [NREQ-1:0] aged,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    always_comb begin
        int idx;
        winner = '0;
        valid  = |active;
        idx    = 0;
        if (|aged) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (aged[IW'(i)]) winner = IW'(i);
            end
        end else begin
            // Descending scan so the closest index after rr_ptr is written last.
            for (int k = NREQ - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (active[IW'(idx)]) winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single RAM port among NREQ requesters with round robin,
// starvation override and bounded retry on RAM ERROR.
module ram_port_arbiter
    import cpu_types_pkg::*;
    import ram_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_WAIT  = 3,
    parameter int MAX_RETRY = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         req_ren,
    input  logic [NREQ-1:0]         req_wen,
    input  word_t                   req_addr [NREQ],
    input  word_t                   req_store [NREQ],
    output logic [NREQ-1:0]         req_wait,
    output word_t                   req_load,
    output logic [NREQ-1:0]         req_err,
    output logic                    ramREN,
    output logic                    ramWEN,
    output word_t                   ramaddr,
    output word_t                   ramstore,
    input  word_t                   ramload,
    input  ramstate_t               ramstate,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy
);

    localparam int IW = $clog2(NREQ);
    localparam int AW = $clog2(MAX_WAIT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   owner_q, rr_ptr_q, win;
    op_t             op_q;
    word_t           addr_q, store_q;
    logic [RW-1:0]   retry_q;
    logic [AW-1:0]   age_q [NREQ];
    logic [NREQ-1:0] active, aged;
    logic            win_vld, own_act;
    logic            done, fail, abort, retry_inc;

    assign active  = req_ren | req_wen;
    assign own_act = active[owner_q];

    always_comb begin
        aged = '0;
        for (int i = 0; i < NREQ; i++) begin
            aged[IW'(i)] = active[IW'(i)] && (age_q[i] >= AW'(MAX_WAIT));
        end
    end

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .active (active),
        .rr_ptr (rr_ptr_q),
        .aged   (aged),
        .winner (win),
        .valid  (win_vld)
    );

    always_comb begin
        state_d   = state_q;
        done      = 1'b0;
        fail      = 1'b0;
        abort     = 1'b0;
        retry_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_vld) state_d = ISSUE;
            end
            ISSUE: begin
                if (!own_act) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (ramstate == ERROR) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_inc = 1'b1;
                        state_d   = RETRY;
                    end else begin
                        done    = 1'b1;
                        fail    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            RETRY: state_d = ISSUE;
            default: state_d = IDLE;
        endcase
    end

    // Enables are gated by the owner's request so an abort drops them at once.
    assign ramREN   = (state_q == ISSUE) && own_act && (op_q == OP_RD);
    assign ramWEN   = (state_q == ISSUE) && own_act && (op_q == OP_WR);
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign owner    = owner_q;
    assign busy     = (state_q != IDLE);

    always_comb begin
        req_wait = '1;
        req_err  = '0;
        req_load = '0;
        if (done) begin
            req_wait[owner_q] = 1'b0;
            req_err[owner_q]  = fail;
            if (op_q == OP_RD) req_load = ramload;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            op_q     <= OP_RD;
            addr_q   <= '0;
            store_q  <= '0;
            retry_q  <= '0;
            for (int i = 0; i < NREQ; i++) age_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (win_vld && active[IW'(i)] && (IW'(i) != win)) begin
                        if (age_q[i] != AW'(MAX_WAIT)) age_q[i] <= age_q[i] + AW'(1);
                    end else begin
                        age_q[i] <= '0;
                    end
                end
                if (win_vld) begin
                    owner_q <= win;
                    addr_q  <= req_addr[win];
                    store_q <= req_store[win];
                    op_q    <= req_wen[win] ? OP_WR : OP_RD;
                end
            end
            if (done || abort) begin
                retry_q  <= '0;
                rr_ptr_q <= (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
            end else if (retry_inc) begin
                retry_q <= retry_q + RW'(1);
            end
        end
    end

endmodule
